// File: rtl/jstk_dir_filter.sv
// Joystick direction filter: turns strobed X/Y position samples into a debounced,
// hysteretic 3-bit direction code with change and auto-repeat move strobes.
module jstk_dir_filter #(
  parameter int DATA_W     = 10,
  parameter int HI_TH      = 800,
  parameter int LO_TH      = 200,
  parameter int HYST       = 32,
  parameter int STABLE_CNT = 3,
  parameter int REPEAT     = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] pos_x,
  input  logic [DATA_W-1:0] pos_y,
  output logic [2:0]        DIR,
  output logic              dir_chg,
  output logic              dir_pulse
);

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_LEFT  = 3'd4
  } dir_t;

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam int REP_W = (REPEAT > 0) ? $clog2(REPEAT + 1) : 1;

  localparam logic [DATA_W-1:0] TH_HI     = DATA_W'(HI_TH);
  localparam logic [DATA_W-1:0] TH_LO     = DATA_W'(LO_TH);
  localparam logic [DATA_W-1:0] TH_HI_REL = DATA_W'(HI_TH - HYST);
  localparam logic [DATA_W-1:0] TH_LO_REL = DATA_W'(LO_TH + HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CNT);
  localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT);

  logic              r_s_v;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  dir_t              r_dir;
  dir_t              r_pending;
  logic [CNT_W-1:0]  r_cnt;
  logic [REP_W-1:0]  r_rep;
  logic              r_chg;
  logic              r_pulse;

  logic              w_hold;
  dir_t              w_cand;
  dir_t              w_pend_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_commit;
  logic [REP_W-1:0]  w_rep_inc;
  logic              w_rep_hit;

  // The committed direction is kept while its relaxed (hysteresis) condition holds;
  // otherwise the normal thresholds pick a candidate in fixed priority order.
  always_comb begin
    w_hold = 1'b0;
    case (r_dir)
      DIR_UP:    w_hold = (r_y > TH_HI_REL);
      DIR_DOWN:  w_hold = (r_y < TH_LO_REL);
      DIR_RIGHT: w_hold = (r_x > TH_HI_REL);
      DIR_LEFT:  w_hold = (r_x < TH_LO_REL);
      default:   w_hold = 1'b0;
    endcase

    if (w_hold)            w_cand = r_dir;
    else if (r_y > TH_HI)  w_cand = DIR_UP;
    else if (r_y < TH_LO)  w_cand = DIR_DOWN;
    else if (r_x > TH_HI)  w_cand = DIR_RIGHT;
    else if (r_x < TH_LO)  w_cand = DIR_LEFT;
    else                   w_cand = DIR_NONE;

    w_pend_next = r_pending;
    if (w_cand == r_dir) begin
      w_cnt_next = '0;
    end else if (w_cand == r_pending) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
    end else begin
      w_pend_next = w_cand;
      w_cnt_next  = CNT_W'(1);
    end

    w_commit  = (w_cnt_next == CNT_MAX);
    w_rep_inc = r_rep + REP_W'(1);
    w_rep_hit = (REPEAT != 0) && (w_rep_inc == REP_MAX);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_s_v     <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_dir     <= DIR_NONE;
      r_pending <= DIR_NONE;
      r_cnt     <= '0;
      r_rep     <= '0;
      r_chg     <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_s_v   <= sample_valid;
      r_chg   <= 1'b0;
      r_pulse <= 1'b0;
      if (sample_valid) begin
        r_x <= pos_x;
        r_y <= pos_y;
      end
      if (r_s_v) begin
        r_pending <= w_pend_next;
        if (w_commit) begin
          r_dir   <= w_cand;
          r_cnt   <= '0;
          r_rep   <= '0;
          r_chg   <= 1'b1;
          r_pulse <= (w_cand != DIR_NONE);
        end else begin
          r_cnt <= w_cnt_next;
          // Repeat counting only advances while a direction is held.
          if (r_dir != DIR_NONE && REPEAT != 0) begin
            if (w_rep_hit) begin
              r_pulse <= 1'b1;
              r_rep   <= '0;
            end else begin
              r_rep <= w_rep_inc;
            end
          end
        end
      end
    end
  end

  assign DIR       = r_dir;
  assign dir_chg   = r_chg;
  assign dir_pulse = r_pulse;

endmodule

// File: tb/tb_jstk_dir_filter.sv
// Bench for jstk_dir_filter: directed scenarios plus random samples, every cycle
// compared against a behavioural model for default and REPEAT=0 instances.
module tb_jstk_dir_filter;

  localparam int STABLE = 3;
  localparam int HI = 800, LO = 200, HY = 32;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       sample_valid = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] pos_y = '0;
  logic [2:0] dir_a, dir_b;
  logic       chg_a, chg_b, pulse_a, pulse_b;

  always #5 CLK = ~CLK;

  jstk_dir_filter dut_a (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .pos_x(pos_x), .pos_y(pos_y),
    .DIR(dir_a), .dir_chg(chg_a), .dir_pulse(pulse_a)
  );

  jstk_dir_filter #(.REPEAT(0)) dut_b (
    .CLK(CLK), .RST(RST), .sample_valid(sample_valid), .pos_x(pos_x), .pos_y(pos_y),
    .DIR(dir_b), .dir_chg(chg_b), .dir_pulse(pulse_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: index 0 mirrors REPEAT=4, index 1 mirrors REPEAT=0.
  int rep_len[2] = '{4, 0};
  int m_dir[2], m_pend[2], m_cnt[2], m_rep[2], e_chg[2], e_pulse[2];
  bit m_sv;
  int m_x, m_y;

  int n_chg_a, n_pulse_a, n_chg_b, n_pulse_b;
  logic [2:0] s_dir;
  logic       s_chg, s_pulse, s2_chg, s2_pulse;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Direction the joystick points at, given what is currently committed.
  function automatic int classify(input int cur, input int x, input int y);
    if (cur == 1 && y > HI - HY) return cur;
    if (cur == 2 && y < LO + HY) return cur;
    if (cur == 3 && x > HI - HY) return cur;
    if (cur == 4 && x < LO + HY) return cur;
    if (y > HI) return 1;
    if (y < LO) return 2;
    if (x > HI) return 3;
    if (x < LO) return 4;
    return 0;
  endfunction

  task automatic model_edge(input bit rst, input bit sv, input int x, input int y);
    for (int k = 0; k < 2; k++) begin
      e_chg[k]   = 0;
      e_pulse[k] = 0;
      if (!rst) begin
        m_dir[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; m_rep[k] = 0;
      end else if (m_sv) begin
        int cand;
        cand = classify(m_dir[k], m_x, m_y);
        if (cand == m_dir[k]) m_cnt[k] = 0;
        else if (cand == m_pend[k]) m_cnt[k] = (m_cnt[k] < STABLE) ? m_cnt[k] + 1 : STABLE;
        else begin m_pend[k] = cand; m_cnt[k] = 1; end
        if (m_cnt[k] == STABLE) begin
          m_dir[k] = cand; m_cnt[k] = 0; m_rep[k] = 0;
          e_chg[k] = 1; e_pulse[k] = (cand != 0);
        end else if (m_dir[k] != 0 && rep_len[k] != 0) begin
          m_rep[k]++;
          if (m_rep[k] == rep_len[k]) begin e_pulse[k] = 1; m_rep[k] = 0; end
        end
      end
    end
    if (!rst) begin
      m_sv = 0; m_x = 0; m_y = 0;
    end else begin
      m_sv = sv;
      if (sv) begin m_x = x; m_y = y; end
    end
  endtask

  task automatic cycle(input bit rst, input bit sv, input int x, input int y);
    RST = rst; sample_valid = sv; pos_x = 10'(x); pos_y = 10'(y);
    @(posedge CLK); #1;
    model_edge(rst, sv, x, y);
    check("dir_a",   dir_a,   m_dir[0]);
    check("chg_a",   chg_a,   e_chg[0]);
    check("pulse_a", pulse_a, e_pulse[0]);
    check("dir_b",   dir_b,   m_dir[1]);
    check("chg_b",   chg_b,   e_chg[1]);
    check("pulse_b", pulse_b, e_pulse[1]);
    if (chg_a)   n_chg_a++;
    if (pulse_a) n_pulse_a++;
    if (chg_b)   n_chg_b++;
    if (pulse_b) n_pulse_b++;
  endtask

  // One strobed sample followed by four idle cycles carrying junk on the inputs.
  task automatic sample(input int x, input int y);
    cycle(1, 1, x, y);
    cycle(1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    s_dir = dir_a; s_chg = chg_a; s_pulse = pulse_a;
    cycle(1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    s2_chg = chg_a; s2_pulse = pulse_a;
    repeat (2) cycle(1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
  endtask

  function automatic int pick_val();
    int tbl[16] = '{0, 100, 199, 200, 201, 231, 232, 233, 512, 767, 768, 769, 799, 800, 801, 1023};
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 1023);
    return tbl[$urandom_range(0, 15)];
  endfunction

  initial begin
    int base_chg;
    // Reset with a strobe present: must be discarded.
    cycle(0, 1, 512, 1000);
    cycle(0, 1, 512, 1000);
    check("rst_dir", dir_a, 0);
    check("rst_chg", chg_a, 0);
    sample(512, 1000);
    sample(512, 1000);
    check("post_rst_no_commit", s_dir, 0);
    sample(512, 1000);
    check("post_rst_commit", s_dir, 1);

    repeat (3) sample(512, 512);
    check("center_dir", s_dir, 0);

    // Debounce commit.
    sample(512, 900);
    check("deb_s1", s_dir, 0);
    sample(512, 900);
    check("deb_s2", s_dir, 0);
    sample(512, 900);
    check("deb_dir", s_dir, 1);
    check("deb_chg", s_chg, 1);
    check("deb_pulse", s_pulse, 1);
    check("deb_chg_1cyc", s2_chg, 0);
    check("deb_pulse_1cyc", s2_pulse, 0);

    repeat (3) sample(512, 512);
    // Broken run.
    sample(512, 900); sample(512, 900); sample(512, 512);
    sample(512, 900); sample(512, 900);
    check("broken_no_commit", s_dir, 0);
    sample(512, 900);
    check("broken_commit", s_dir, 1);

    // Hysteresis.
    repeat (3) sample(512, 790);
    check("hyst_hold", s_dir, 1);
    sample(512, 760); sample(512, 760);
    check("hyst_pending", s_dir, 1);
    sample(512, 760);
    check("hyst_release_dir", s_dir, 0);
    check("hyst_release_chg", s_chg, 1);
    check("hyst_release_pulse", s_pulse, 0);

    // Priority and stickiness.
    repeat (3) sample(1000, 100);
    check("prio_down", s_dir, 2);
    repeat (3) sample(900, 512);
    check("right_commit", s_dir, 3);
    base_chg = n_chg_a;
    repeat (5) sample(900, 900);
    check("sticky_dir", s_dir, 3);
    check("sticky_no_chg", n_chg_a - base_chg, 0);

    // Back-to-back strobes with repeat.
    repeat (3) sample(512, 512);
    n_chg_a = 0; n_pulse_a = 0; n_chg_b = 0; n_pulse_b = 0;
    repeat (12) cycle(1, 1, 512, 900);
    repeat (2) cycle(1, 0, 512, 512);
    check("b2b_chg_a", n_chg_a, 1);
    check("b2b_pulse_a", n_pulse_a, 3);
    check("b2b_chg_b", n_chg_b, 1);
    check("b2b_pulse_b", n_pulse_b, 1);

    // Random phase including dense strobes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 2) == 0, pick_val(), pick_val());
    end
    cycle(1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jstk_dir_filter.md
# jstk_dir_filter

Parametrised successor to the joystick position decoder. Converts PmodJSTK X/Y position samples into a stable 3-bit direction code with configurable thresholds, per-direction hysteresis, sample-count debouncing and an auto-repeat move strobe. Sits between the PmodJSTK interface (fed on each completed 5 Hz transfer) and the game movement logic.

## Interface
Parameters:
- DATA_W, 10: width of each position axis.
- HI_TH, 800: axis value above which up/right is detected.
- LO_TH, 200: axis value below which down/left is detected.
- HYST, 32: hysteresis margin applied to the currently committed direction.
- STABLE_CNT, 3: consecutive identical samples required to commit a new direction (min 1).
- REPEAT, 4: samples between repeat strobes while a direction is held; 0 disables repeat.

Legal parameter values: LO_TH + HYST < HI_TH − HYST and STABLE_CNT ≥ 1. All comparisons are unsigned at DATA_W bits, and the threshold constants fit in DATA_W.

Ports:
- CLK, in, 1: system clock; the only clock in the block.
- RST, in, 1: synchronous, active-low reset.
- sample_valid, in, 1: one-cycle strobe marking a new X/Y sample.
- pos_x, in, DATA_W: X position, {jstkData[9:8], jstkData[23:16]}.
- pos_y, in, DATA_W: Y position, {jstkData[25:24], jstkData[39:32]}.
- DIR, out, 3: committed direction. 0 = none, 1 = up, 2 = down, 3 = right, 4 = left.
- dir_chg, out, 1: one-cycle pulse whenever DIR changes, including a change to 0.
- dir_pulse, out, 1: one-cycle move strobe. Fires on a commit to a nonzero direction and on each repeat.

## Operation
- **Capture stage:** on an edge with sample_valid=1, register pos_x and pos_y and set the internal flag s_v. Otherwise s_v=0.
- **Classify stage:** runs only when s_v=1, using the registered sample and the current DIR.
  - Hold rule: if the committed direction's relaxed condition is true, the candidate equals DIR. Relaxed conditions: up Y > HI_TH−HYST; down Y < LO_TH+HYST; right X > HI_TH−HYST; left X < LO_TH+HYST.
  - Priority rule: if the hold rule does not apply, use normal thresholds in priority order: Y>HI_TH → 1, Y<LO_TH → 2, X>HI_TH → 3, X<LO_TH → 4, else 0.
- **Debounce:** uses registers pending (3 bits) and cnt (saturating, wide enough for STABLE_CNT).
  - candidate == DIR: cnt ← 0.
  - candidate ≠ DIR and candidate == pending: cnt ← cnt+1.
  - Otherwise: pending ← candidate and cnt ← 1.
  - When the updated cnt equals STABLE_CNT: DIR ← candidate, cnt ← 0, dir_chg=1.
  - STABLE_CNT=1 commits on the first differing sample.
- **Repeat:** uses rep_cnt.
  - Cleared on every commit.
  - While DIR≠0, with no commit and REPEAT≠0, each processed sample increments rep_cnt.
  - When rep_cnt reaches REPEAT: dir_pulse=1 and rep_cnt ← 0.
  - rep_cnt holds while DIR=0.
- Samples that arrive between strobes are ignored; only strobed data is used.

## Timing
- Latency: a sample strobed at edge k is classified at edge k+1. DIR, dir_chg and dir_pulse update on that edge and are visible during cycle k+1.
- dir_chg and dir_pulse are high for exactly one cycle per event and are 0 on every cycle with s_v=0.
- Back-to-back strobes (every cycle) are supported at one sample per cycle with no loss.
- On a commit to nonzero: dir_chg and dir_pulse fire in the same cycle.
- On a commit to 0: only dir_chg fires.
- Reset values (RST=0 at an edge): DIR=0, dir_chg=0, dir_pulse=0, pending=0, cnt=0, rep_cnt=0, s_v=0, captured X/Y=0.
- A strobe coincident with reset is discarded.
- Reset mid-debounce or mid-repeat abandons the run. The first post-reset sample starts a fresh count.

## Test plan
All cases use default parameters and X=512 unless stated; strobes are 5 cycles apart.
- **Reset:** RST=0 for 2 cycles with sample_valid=1 and Y=1000, then release. Required: DIR=0 and no pulses during or after reset until 3 further samples arrive.
- **Debounce commit:** Y=900 ×3. Required: DIR stays 0 after samples 1 and 2. DIR=1 one cycle after sample 3, with dir_chg=dir_pulse=1 for that cycle only.
- **Broken run:** Y=900, 900, 512, 900, 900, 900. Required: no commit until the 6th sample, then DIR=1.
- **Hysteresis:** from DIR=1, Y=790 ×3. Required: DIR stays 1 because 790 > 768. Then Y=760 ×3. Required: DIR=0 after the third sample, with dir_chg=1 and dir_pulse=0.
- **Priority and stickiness:**
  - From DIR=0, Y=100 and X=1000 ×3. Required: DIR=2.
  - Separately, commit DIR=3 with X=900, then apply Y=900 and X=900 ×5. Required: DIR stays 3 and dir_chg never fires.
- **Repeat and back-to-back strobes:** hold Y=900 with sample_valid=1 every cycle for 12 cycles. Required: commit on the 3rd sample, then dir_pulse on the 7th and 11th samples (REPEAT=4), and a single dir_chg in total. With REPEAT=0, dir_pulse fires only at the commit.
